axis_bram_xfer_seq: RTL and testbench
=====================================

Name: axis_bram_xfer_seq

Overview:
Transfer sequencer that sits directly upstream of the AXIS<->BRAM adapter controller. It accepts one transfer command at a time: direction plus start and bound BRAM row indices. It then drives the controller's rw, addr_reload and row-index inputs, and gates the AXI-Stream handshakes so that exactly (bound-start+1)*BRAM_WIDTH_IN_WORD beats pass. It reports completion or a command error.

Parameters:
BRAM_ADDR_LENGTH, 12, BRAM row index width
BRAM_WIDTH_IN_WORD, 36, stream words per BRAM row
CNT_W, 6, word counter width (2^CNT_W >= BRAM_WIDTH_IN_WORD)

Ports:
clk  in  1  clock
rstn  in  1  reset, synchronous, active-low
cmd_valid  in  1  command offered
cmd_ready  out  1  sequencer can accept a command
cmd_rw  in  1  1 = stream->BRAM write, 0 = BRAM->stream read
cmd_start  in  BRAM_ADDR_LENGTH  first row
cmd_bound  in  BRAM_ADDR_LENGTH  last row (inclusive)
rw  out  1  to controller rw
addr_reload  out  1  to controller addr_reload
bram_start_index  out  BRAM_ADDR_LENGTH  to controller
bram_bound_index  out  BRAM_ADDR_LENGTH  to controller
s_axis_tvalid  in  1  external write-stream valid
s_axis_tready  out  1  external write-stream ready
ad_stream_in_valid  out  1  to controller stream_in_valid
ad_stream_in_accep  in  1  from controller stream_in_accep
m_axis_tvalid  out  1  external read-stream valid
m_axis_tready  in  1  external read-stream ready
m_axis_tlast  out  1  external read-stream last
ad_stream_out_valid  in  1  from controller stream_out_valid
ad_stream_out_accep  out  1  to controller stream_out_accep
ad_stream_out_tlast  in  1  from controller stream_out_tlast
busy  out  1  transfer in progress (state != IDLE)
done  out  1  one-cycle completion pulse
err  out  1  one-cycle error pulse

Behaviour:
- Reset: state = IDLE. All of these are 0: rw, addr_reload, start/bound index registers, word_cnt, row_idx, done, err, all gated handshakes. cmd_ready = 1 in IDLE.
- Reset mid-transfer aborts to IDLE on the next clock. No done is issued.
- States: IDLE, LOAD, RUN, DRAIN, DONE.
- IDLE:
  - cmd_ready = 1.
  - On cmd_valid, the command is consumed.
  - If cmd_bound < cmd_start (unsigned): err = 1 next cycle and the state stays IDLE. rw, addr_reload and the index registers are unchanged.
  - Otherwise: register cmd_rw into rw, cmd_start into bram_start_index and row_idx, cmd_bound into bram_bound_index. word_cnt = 0. Go to LOAD.
- LOAD:
  - Lasts exactly 1 cycle. addr_reload = 1, all gates closed, cmd_ready = 0.
  - Go to RUN.
  - rw already holds its new value during LOAD, so the controller's rw history settles before RUN.
- RUN, write (rw = 1):
  - s_axis_tready = ad_stream_in_accep.
  - ad_stream_in_valid = s_axis_tvalid.
  - beat = s_axis_tvalid & s_axis_tready.
- RUN, read (rw = 0):
  - m_axis_tvalid = ad_stream_out_valid.
  - ad_stream_out_accep = m_axis_tready.
  - beat = m_axis_tvalid & m_axis_tready.
- Counting, on each beat:
  - word_cnt increments. At BRAM_WIDTH_IN_WORD-1 it wraps to 0 and row_idx increments.
  - last_beat = (word_cnt == BRAM_WIDTH_IN_WORD-1) && (row_idx == bram_bound_index). The equality compare makes bound = 2^BRAM_ADDR_LENGTH-1 legal.
- Read completion:
  - m_axis_tlast = m_axis_tvalid && last_beat. This is generated internally and is authoritative.
  - If ad_stream_out_tlast != last_beat on any read beat, err pulses 1 cycle and the transfer continues.
  - On the last beat, the state goes to DONE.
- Write completion:
  - On the last beat, the state goes to DRAIN. All gates close from the next cycle, so no beat beyond the count passes.
- DRAIN: exactly 2 cycles, which lets the controller's final row write (en/wen pulse, then index increment) retire. Then go to DONE.
- DONE: done = 1 for 1 cycle, busy = 1 during it. Then go to IDLE.
- Outside RUN:
  - s_axis_tready = 0, m_axis_tvalid = 0, m_axis_tlast = 0.
  - ad_stream_in_valid = 0, ad_stream_out_accep = 0.
- rw retains its last value in IDLE.
- A new command is accepted on the cycle after done, at the earliest.
- Stalls: no beat means no count change. Back-to-back beats on consecutive cycles are counted every cycle.

Test Plan:
- Write, start=5 bound=6, continuous s_axis_tvalid -> addr_reload high 1 cycle with start=5. Exactly 72 beats accepted. s_axis_tready is 0 from the cycle after beat 72. done 3 cycles after beat 72.
- Read, start=0 bound=0, m_axis_tready=1 -> 36 beats. m_axis_tlast only on beat 36. done the next cycle. err=0 when the controller's tlast agrees.
- Read, start=2 bound=3, m_axis_tready toggling 1/0 every cycle -> 72 beats total. Counters hold on stalls. tlast on beat 72 only.
- Command start=4 bound=3 -> err pulse 1 cycle, no addr_reload, busy stays 0, cmd_ready stays 1.
- rstn low during RUN after 10 write beats -> IDLE next cycle, all outputs 0, no done. A new command is accepted afterwards.
- Read with ad_stream_out_tlast forced high on beat 36 of a 72-beat transfer -> err pulse. Transfer still completes at beat 72 with done.

Source files
------------

// File: rtl/axis_bram_xfer_seq_if.sv
// Command, controller and stream handshake bundle for the transfer sequencer.
// master = sequencer side, slave = command source / controller / stream side.
interface axis_bram_xfer_seq_if #(
  parameter int BRAM_ADDR_LENGTH = 12
);
  logic                        cmd_valid;
  logic                        cmd_ready;
  logic                        cmd_rw;
  logic [BRAM_ADDR_LENGTH-1:0] cmd_start;
  logic [BRAM_ADDR_LENGTH-1:0] cmd_bound;
  logic                        rw;
  logic                        addr_reload;
  logic [BRAM_ADDR_LENGTH-1:0] bram_start_index;
  logic [BRAM_ADDR_LENGTH-1:0] bram_bound_index;
  logic                        s_axis_tvalid;
  logic                        s_axis_tready;
  logic                        ad_stream_in_valid;
  logic                        ad_stream_in_accep;
  logic                        m_axis_tvalid;
  logic                        m_axis_tready;
  logic                        m_axis_tlast;
  logic                        ad_stream_out_valid;
  logic                        ad_stream_out_accep;
  logic                        ad_stream_out_tlast;
  logic                        busy;
  logic                        done;
  logic                        err;

  modport master (
    input  cmd_valid, cmd_rw, cmd_start, cmd_bound,
    input  s_axis_tvalid, ad_stream_in_accep,
    input  m_axis_tready, ad_stream_out_valid,
    input  ad_stream_out_tlast,
    output cmd_ready, rw, addr_reload,
    output bram_start_index, bram_bound_index,
    output s_axis_tready, ad_stream_in_valid,
    output m_axis_tvalid, m_axis_tlast,
    output ad_stream_out_accep,
    output busy, done, err
  );

  modport slave (
    output cmd_valid, cmd_rw, cmd_start, cmd_bound,
    output s_axis_tvalid, ad_stream_in_accep,
    output m_axis_tready, ad_stream_out_valid,
    output ad_stream_out_tlast,
    input  cmd_ready, rw, addr_reload,
    input  bram_start_index, bram_bound_index,
    input  s_axis_tready, ad_stream_in_valid,
    input  m_axis_tvalid, m_axis_tlast,
    input  ad_stream_out_accep,
    input  busy, done, err
  );
endinterface

// File: rtl/axis_bram_xfer_seq.sv
// Transfer sequencer ahead of the AXIS<->BRAM adapter: takes one row-range
// command, gates the stream handshakes to an exact beat count, reports done/err.
module axis_bram_xfer_seq #(
  parameter int BRAM_ADDR_LENGTH   = 12,
  parameter int BRAM_WIDTH_IN_WORD = 36,
  parameter int CNT_W              = 6
) (
  input  logic                 clk,
  input  logic                 rstn,
  axis_bram_xfer_seq_if.master bus
);
  localparam int AW = BRAM_ADDR_LENGTH;
  localparam logic [CNT_W-1:0] WLAST =
    CNT_W'(BRAM_WIDTH_IN_WORD - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic             rw_q;
  logic [AW-1:0]    start_q, bound_q;
  logic [AW-1:0]    row_q, row_d;
  logic [CNT_W-1:0] wcnt_q, wcnt_d;
  logic             err_q, err_d;
  logic             drain_q;

  logic             run;
  logic             beat;
  logic             last;
  logic             bad_cmd;
  logic             accept;

  assign bad_cmd = bus.cmd_bound < bus.cmd_start;
  assign accept  = (state_q == S_IDLE) & bus.cmd_valid & ~bad_cmd;
  assign last    = (wcnt_q == WLAST) & (row_q == bound_q);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (accept) state_d = S_LOAD;
      S_LOAD:  state_d = S_RUN;
      S_RUN: begin
        if (beat && last) state_d = rw_q ? S_DRAIN : S_DONE;
      end
      S_DRAIN: if (drain_q) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    run                     = state_q == S_RUN;
    bus.cmd_ready           = state_q == S_IDLE;
    bus.addr_reload         = state_q == S_LOAD;
    bus.busy                = state_q != S_IDLE;
    bus.done                = state_q == S_DONE;
    bus.s_axis_tready       = run & rw_q & bus.ad_stream_in_accep;
    bus.ad_stream_in_valid  = run & rw_q & bus.s_axis_tvalid;
    bus.m_axis_tvalid       = run & ~rw_q & bus.ad_stream_out_valid;
    bus.ad_stream_out_accep = run & ~rw_q & bus.m_axis_tready;
    bus.m_axis_tlast        = bus.m_axis_tvalid & last;
    beat = rw_q ? (bus.s_axis_tvalid & bus.s_axis_tready)
                : (bus.m_axis_tvalid & bus.m_axis_tready);
  end

  always_comb begin
    wcnt_d = wcnt_q + CNT_W'(1);
    row_d  = row_q;
    if (wcnt_q == WLAST) begin
      wcnt_d = '0;
      row_d  = row_q + AW'(1);
    end
    // controller's tlast is only cross-checked; ours drives the stream
    err_d = ((state_q == S_IDLE) & bus.cmd_valid & bad_cmd)
          | (beat & ~rw_q & (bus.ad_stream_out_tlast != last));
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      rw_q    <= 1'b0;
      start_q <= '0;
      bound_q <= '0;
      row_q   <= '0;
      wcnt_q  <= '0;
      err_q   <= 1'b0;
      drain_q <= 1'b0;
    end else begin
      err_q   <= err_d;
      drain_q <= (state_q == S_DRAIN) & ~drain_q;
      if (accept) begin
        rw_q    <= bus.cmd_rw;
        start_q <= bus.cmd_start;
        bound_q <= bus.cmd_bound;
        row_q   <= bus.cmd_start;
        wcnt_q  <= '0;
      end else if (beat) begin
        wcnt_q <= wcnt_d;
        row_q  <= row_d;
      end
    end
  end

  assign bus.rw               = rw_q;
  assign bus.bram_start_index = start_q;
  assign bus.bram_bound_index = bound_q;
  assign bus.err              = err_q;
endmodule

// File: tb/tb_axis_bram_xfer_seq.sv
// Directed bench for axis_bram_xfer_seq: write/read transfers, stalls,
// bad command, mid-transfer reset and controller tlast disagreement.
module tb_axis_bram_xfer_seq;
  logic clk = 1'b0;
  logic rstn;
  int   n_chk = 0;
  int   n_fail = 0;

  int   beats, reloads, rl_start, errs, dones;
  int   tlasts, tlast_at, lastb_cyc, done_cyc, rdy_after;

  always #5 clk = ~clk;

  axis_bram_xfer_seq_if #(.BRAM_ADDR_LENGTH(12)) bus ();

  axis_bram_xfer_seq #(
    .BRAM_ADDR_LENGTH  (12),
    .BRAM_WIDTH_IN_WORD(36),
    .CNT_W             (6)
  ) dut (
    .clk (clk),
    .rstn(rstn),
    .bus (bus)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.cmd_valid           = 1'b0;
    bus.cmd_rw              = 1'b0;
    bus.cmd_start           = '0;
    bus.cmd_bound           = '0;
    bus.s_axis_tvalid       = 1'b0;
    bus.ad_stream_in_accep  = 1'b0;
    bus.m_axis_tready       = 1'b0;
    bus.ad_stream_out_valid = 1'b0;
    bus.ad_stream_out_tlast = 1'b0;
  endtask

  // Issues a command and runs the stream until one cycle past done,
  // a budget expiry, or abort_at beats have been seen.
  task automatic xfer(input logic rw, input int st, input int bd,
                      input bit tog, input int force_beat,
                      input int abort_at);
    int total;
    bit b;
    total = (bd - st + 1) * 36;
    beats = 0; reloads = 0; rl_start = -1; errs = 0; dones = 0;
    tlasts = 0; tlast_at = 0; lastb_cyc = -1; done_cyc = -1;
    rdy_after = 0;
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_rw    = rw;
    bus.cmd_start = 12'(st);
    bus.cmd_bound = 12'(bd);
    #1 chk("cmd_ready_idle", int'(bus.cmd_ready), 1);
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      bus.cmd_valid           = 1'b0;
      bus.s_axis_tvalid       = rw;
      bus.ad_stream_in_accep  = 1'b1;
      bus.ad_stream_out_valid = ~rw;
      bus.m_axis_tready       = tog ? c[0] : 1'b1;
      bus.ad_stream_out_tlast = (beats + 1 == total)
                              ^ (beats + 1 == force_beat);
      #1;
      if (bus.addr_reload) begin
        reloads++;
        rl_start = int'(bus.bram_start_index);
      end
      b = rw ? (bus.s_axis_tvalid & bus.s_axis_tready)
             : (bus.m_axis_tvalid & bus.m_axis_tready);
      if (rw && lastb_cyc >= 0 && bus.s_axis_tready) rdy_after++;
      if (b) begin
        beats++;
        if (bus.m_axis_tlast) begin
          tlasts++;
          tlast_at = beats;
        end
        if (beats == total) lastb_cyc = c;
      end
      if (bus.err) errs++;
      if (bus.done) begin
        dones++;
        done_cyc = c;
      end
      if (done_cyc >= 0 && c > done_cyc) break;
      if (abort_at > 0 && beats == abort_at) break;
    end
  endtask

  initial begin
    idle_inputs();
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_cmd_ready", int'(bus.cmd_ready), 1);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_rw", int'(bus.rw), 0);
    chk("rst_reload", int'(bus.addr_reload), 0);
    chk("rst_start", int'(bus.bram_start_index), 0);
    chk("rst_bound", int'(bus.bram_bound_index), 0);
    chk("rst_done_err", int'({bus.done, bus.err}), 0);
    chk("rst_gates", int'({bus.s_axis_tready, bus.m_axis_tvalid,
                           bus.ad_stream_in_valid,
                           bus.ad_stream_out_accep}), 0);
    rstn = 1'b1;

    // write rows 5..6
    xfer(1'b1, 5, 6, 1'b0, 0, 0);
    chk("w_reloads", reloads, 1);
    chk("w_reload_start", rl_start, 5);
    chk("w_bound_idx", int'(bus.bram_bound_index), 6);
    chk("w_beats", beats, 72);
    chk("w_ready_after", rdy_after, 0);
    chk("w_done_gap", done_cyc - lastb_cyc, 3);
    chk("w_dones", dones, 1);
    chk("w_errs", errs, 0);
    chk("w_idle_busy", int'(bus.busy), 0);
    chk("w_rw_held", int'(bus.rw), 1);
    idle_inputs();

    // read row 0
    xfer(1'b0, 0, 0, 1'b0, 0, 0);
    chk("r0_beats", beats, 36);
    chk("r0_tlasts", tlasts, 1);
    chk("r0_tlast_at", tlast_at, 36);
    chk("r0_done_gap", done_cyc - lastb_cyc, 1);
    chk("r0_errs", errs, 0);
    chk("r0_rw", int'(bus.rw), 0);
    idle_inputs();

    // read rows 2..3 with tready toggling
    xfer(1'b0, 2, 3, 1'b1, 0, 0);
    chk("rt_beats", beats, 72);
    chk("rt_tlasts", tlasts, 1);
    chk("rt_tlast_at", tlast_at, 72);
    chk("rt_dones", dones, 1);
    chk("rt_errs", errs, 0);
    idle_inputs();

    // bad command: bound < start
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_rw    = 1'b1;
    bus.cmd_start = 12'd4;
    bus.cmd_bound = 12'd3;
    #1 chk("bad_cmd_ready", int'(bus.cmd_ready), 1);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    #1;
    chk("bad_err", int'(bus.err), 1);
    chk("bad_busy", int'(bus.busy), 0);
    chk("bad_reload", int'(bus.addr_reload), 0);
    chk("bad_ready_after", int'(bus.cmd_ready), 1);
    chk("bad_start_kept", int'(bus.bram_start_index), 2);
    chk("bad_rw_kept", int'(bus.rw), 0);
    @(negedge clk);
    #1;
    chk("bad_err_pulse", int'(bus.err), 0);
    chk("bad_busy2", int'(bus.busy), 0);

    // reset during a write after 10 beats
    xfer(1'b1, 0, 1, 1'b0, 0, 10);
    chk("ab_beats", beats, 10);
    @(negedge clk);
    rstn = 1'b0;
    idle_inputs();
    @(negedge clk);
    rstn = 1'b1;
    #1;
    chk("ab_busy", int'(bus.busy), 0);
    chk("ab_done", int'(bus.done), 0);
    chk("ab_rw", int'(bus.rw), 0);
    chk("ab_start", int'(bus.bram_start_index), 0);
    chk("ab_s_ready", int'(bus.s_axis_tready), 0);
    chk("ab_cmd_ready", int'(bus.cmd_ready), 1);
    xfer(1'b1, 1, 1, 1'b0, 0, 0);
    chk("ab_new_beats", beats, 36);
    chk("ab_new_dones", dones, 1);
    chk("ab_new_start", rl_start, 1);
    idle_inputs();

    // read rows 7..8, controller tlast wrong on beat 36
    xfer(1'b0, 7, 8, 1'b0, 36, 0);
    chk("tm_errs", errs, 1);
    chk("tm_beats", beats, 72);
    chk("tm_tlast_at", tlast_at, 72);
    chk("tm_tlasts", tlasts, 1);
    chk("tm_dones", dones, 1);
    idle_inputs();

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
